// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage.
//   fetch_state_t : RUN / HALT / FAULT control states
//   fetch_entry_t : payload presented to decode {pc, pc+4, instr}
package fetch_pkg;

  localparam int unsigned INSTR_W          = 32;
  localparam logic [31:0] EBREAK_INSTR_DEF = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEF     = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [31:0]        pc_plus4;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready payload register between fetch and decode.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   i_load      : capture i_entry and mark valid (only asserted when the slot is free)
//   i_flush     : discard the held entry (dominates load and fire)
//   i_fire      : entry accepted downstream this cycle
//   i_entry     : payload to capture
//   o_valid     : entry valid
//   o_entry     : held payload, stable while valid and not accepted
module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_flush,
  input  logic         i_fire,
  input  fetch_entry_t i_entry,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_entry <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_entry <= i_entry;
    end else if (i_fire) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// PC generation and fetch stage in front of a combinational word-addressed
// instruction memory. Presents {pc, pc+4, instr} to decode under valid/ready.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   imem_addr         : fetch address (always the current pc)
//   imem_rdata        : instruction returned in the same cycle
//   redirect_valid/pc : PC change from execute (highest priority)
//   out_valid/ready   : decode handshake
//   out_pc, out_pc_plus4, out_instr : presented entry
//   halted, fault     : state indicators (HALT / FAULT)
//   fetch_count       : accepted, non-discarded handshakes (wraps)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter int unsigned MEM_WORDS    = 2048,
  parameter logic [31:0] EBREAK_INSTR = EBREAK_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic [31:0] out_instr,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LP_MEM_WORDS = 32'(MEM_WORDS);

  fetch_state_t r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_count;
  logic [31:0]  w_pc_plus4;
  logic         w_fire, w_slot_free, w_pc_bad, w_load;
  fetch_entry_t w_entry_in, w_entry_out;

  assign w_fire      = out_valid & out_ready;
  assign w_slot_free = ~out_valid | out_ready;
  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_pc_bad    = (r_pc[1:0] != 2'b00) || ({2'b00, r_pc[31:2]} >= LP_MEM_WORDS);

  assign w_entry_in = '{pc: r_pc, pc_plus4: w_pc_plus4, instr: imem_rdata};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      // A fire coinciding with a redirect is discarded and not counted.
      if (w_fire && !redirect_valid) r_count <= r_count + 32'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    if (redirect_valid) begin
      w_pc_nxt    = redirect_pc;
      w_state_nxt = RUN;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_slot_free) begin
            if (w_pc_bad) begin
              w_state_nxt = FAULT;
            end else begin
              w_load = 1'b1;
              // EBREAK is still delivered, but pc stays on it.
              if (imem_rdata == EBREAK_INSTR) w_state_nxt = HALT;
              else                            w_pc_nxt    = w_pc_plus4;
            end
          end
        end
        HALT:    w_state_nxt = HALT;
        FAULT:   w_state_nxt = FAULT;
        default: w_state_nxt = RUN;
      endcase
    end
  end

  fetch_out_reg u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_flush (redirect_valid),
    .i_fire  (w_fire),
    .i_entry (w_entry_in),
    .o_valid (out_valid),
    .o_entry (w_entry_out)
  );

  assign imem_addr    = r_pc;
  assign out_pc       = w_entry_out.pc;
  assign out_pc_plus4 = w_entry_out.pc_plus4;
  assign out_instr    = w_entry_out.instr;
  assign halted       = (r_state == HALT);
  assign fault        = (r_state == FAULT);
  assign fetch_count  = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [31:0] mem [0:2047];

  fetch_stage #(
    .RESET_PC     (32'h0000_0000),
    .MEM_WORDS    (2048),
    .EBREAK_INSTR (32'h0010_0073)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4),
    .out_instr      (out_instr),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  // Combinational instruction memory model; out-of-range reads return 0.
  assign imem_rdata = (imem_addr[31:13] == 19'd0) ? mem[imem_addr[12:2]] : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] pc, input logic [31:0] instr);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".pc"},    out_pc, pc);
    check({tag, ".pc4"},   out_pc_plus4, pc + 32'd4);
    check({tag, ".instr"}, out_instr, instr);
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0]    = 32'h0000_0013;
    mem[1]    = 32'h0000_0093;
    mem[2]    = 32'h0000_0113;
    mem[3]    = 32'h0010_0073;
    mem[2047] = 32'hDEAD_BEEF;

    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;
    #2;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.pc",    out_pc, 32'd0);
    check("rst.instr", out_instr, 32'd0);
    check("rst.addr",  imem_addr, 32'd0);
    check("rst.halt",  {31'd0, halted}, 32'd0);
    check("rst.fault", {31'd0, fault}, 32'd0);
    check("rst.cnt",   fetch_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming, then backpressure hold on the pc=4 entry.
    step(); chk_entry("s0", 32'h0, 32'h13);
    check("s0.cnt", fetch_count, 32'd0);
    step(); chk_entry("s1", 32'h4, 32'h93);
    check("s1.addr", imem_addr, 32'h8);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(); chk_entry("hold", 32'h4, 32'h93);
      check("hold.addr", imem_addr, 32'h8);
      check("hold.cnt", fetch_count, 32'd1);
    end
    out_ready = 1'b1;
    step(); chk_entry("s2", 32'h8, 32'h113);
    check("s2.cnt", fetch_count, 32'd2);

    // EBREAK at word 3: delivered, then halt.
    step(); chk_entry("ebrk", 32'hC, 32'h0010_0073);
    check("ebrk.halt", {31'd0, halted}, 32'd1);
    check("ebrk.cnt", fetch_count, 32'd3);
    step();
    check("halt.valid", {31'd0, out_valid}, 32'd0);
    check("halt.cnt", fetch_count, 32'd4);
    check("halt.addr", imem_addr, 32'hC);
    step();
    check("halt2.valid", {31'd0, out_valid}, 32'd0);
    check("halt2.halt", {31'd0, halted}, 32'd1);

    pulse_redirect(32'h0);
    check("rd0.halt", {31'd0, halted}, 32'd0);
    check("rd0.valid", {31'd0, out_valid}, 32'd0);
    check("rd0.addr", imem_addr, 32'h0);
    step(); chk_entry("rd0.e", 32'h0, 32'h13);
    check("rd0.cnt", fetch_count, 32'd4);

    // Redirect while a valid entry fires: dropped and not counted.
    pulse_redirect(32'h10);
    check("rd10.valid", {31'd0, out_valid}, 32'd0);
    check("rd10.cnt", fetch_count, 32'd4);
    step(); chk_entry("rd10.e", 32'h10, 32'h1000_0004);
    pulse_redirect(32'h40);
    check("rd40.valid", {31'd0, out_valid}, 32'd0);
    check("rd40.cnt", fetch_count, 32'd4);
    check("rd40.addr", imem_addr, 32'h40);
    step(); chk_entry("rd40.e", 32'h40, 32'h1000_0010);
    check("rd40.cnt2", fetch_count, 32'd4);

    // Misaligned redirect faults on the next evaluation.
    pulse_redirect(32'h2002);
    check("mis.fault0", {31'd0, fault}, 32'd0);
    check("mis.addr", imem_addr, 32'h2002);
    step();
    check("mis.fault", {31'd0, fault}, 32'd1);
    check("mis.valid", {31'd0, out_valid}, 32'd0);
    step();
    check("mis.sticky", {31'd0, fault}, 32'd1);

    // Last memory word, then pc rolls out of range.
    pulse_redirect(32'h1FFC);
    check("last.fault0", {31'd0, fault}, 32'd0);
    step(); chk_entry("last.e", 32'h1FFC, 32'hDEAD_BEEF);
    check("last.pc4", out_pc_plus4, 32'h2000);
    check("last.addr", imem_addr, 32'h2000);
    step();
    check("oor.fault", {31'd0, fault}, 32'd1);
    check("oor.valid", {31'd0, out_valid}, 32'd0);
    check("oor.cnt", fetch_count, 32'd5);

    // Async reset between edges while streaming.
    pulse_redirect(32'h4);
    step(); step();
    chk_entry("pre.rst", 32'h8, 32'h113);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", {31'd0, out_valid}, 32'd0);
    check("arst.pc",    out_pc, 32'd0);
    check("arst.addr",  imem_addr, 32'd0);
    check("arst.cnt",   fetch_count, 32'd0);
    check("arst.fault", {31'd0, fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); chk_entry("post.rst", 32'h0, 32'h13);
    step(); chk_entry("post.rst1", 32'h4, 32'h93);
    check("post.cnt", fetch_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
